// File: rtl/vga_timing_dither_pkg.sv
// Shared definitions for the VGA output stage: counter widths, dither mode
// encodings and the porch-sum helper used to size the raster.
package vga_pkg;

    localparam int H_W = 11;
    localparam int V_W = 10;

    typedef enum logic [1:0] {
        DM_TRUNC    = 2'd0,
        DM_SPATIAL  = 2'd1,
        DM_TEMPORAL = 2'd2
    } dither_mode_e;

    // Total clocks (or lines) in one period of the raster.
    function automatic int timing_total(input int display, input int front,
                                        input int sync, input int back);
        return display + front + sync + back;
    endfunction

endpackage

// File: rtl/vga_timing_dither_if.sv
// Bus between the VGA output stage and its renderer/monitor: coordinate
// publication, returned source colour, and the DAC-side outputs.
interface vga_timing_dither_if
    import vga_pkg::*;
#(
    parameter int IN_BITS    = 6,
    parameter int OUT_BITS   = 2,
    parameter int FRAME_BITS = 8
);
    logic [H_W-1:0]        h_count;
    logic [V_W-1:0]        v_count;
    logic [FRAME_BITS-1:0] frame;
    logic                  hblank_start;
    logic                  frame_start;
    logic [IN_BITS-1:0]    src_r;
    logic [IN_BITS-1:0]    src_g;
    logic [IN_BITS-1:0]    src_b;
    logic                  hsync;
    logic                  vsync;
    logic [OUT_BITS-1:0]   r_out;
    logic [OUT_BITS-1:0]   g_out;
    logic [OUT_BITS-1:0]   b_out;

    modport master (
        output h_count, v_count, frame, hblank_start, frame_start,
        output hsync, vsync, r_out, g_out, b_out,
        input  src_r, src_g, src_b
    );

    modport slave (
        input  h_count, v_count, frame, hblank_start, frame_start,
        input  hsync, vsync, r_out, g_out, b_out,
        output src_r, src_g, src_b
    );
endinterface

// File: rtl/vga_timing_dither_bayer.sv
// One colour channel of the ordered dither: adds the 8x8 Bayer threshold for
// (bi, bj) to the source colour, then drops SHIFT bits with saturation.
module bayer_dither
    import vga_pkg::*;
#(
    parameter int IN_BITS     = 6,
    parameter int OUT_BITS    = 2,
    parameter int DITHER_MODE = 2
) (
    input  logic [IN_BITS-1:0]  c,
    input  logic [2:0]          bi,
    input  logic [2:0]          bj,
    output logic [OUT_BITS-1:0] q
);
    localparam int SHIFT = IN_BITS - OUT_BITS;

    // Shift away the dither bits; anything above the DAC range clamps to full scale.
    function automatic logic [OUT_BITS-1:0] sat_shift(input logic [IN_BITS:0] s);
        logic [IN_BITS:0] sh;
        sh = s >> SHIFT;
        if (|sh[IN_BITS:OUT_BITS]) begin
            return '1;
        end
        return sh[OUT_BITS-1:0];
    endfunction

    logic [5:0]       m;
    logic [IN_BITS:0] bay;
    logic [IN_BITS:0] sum;

    // Bit-interleaved Bayer index; only its top SHIFT bits act as the threshold.
    always_comb begin
        m   = {bi[0] ^ bj[0], bi[0], bi[1] ^ bj[1], bi[1], bi[2] ^ bj[2], bi[2]};
        bay = (DITHER_MODE == int'(DM_TRUNC)) ? '0 : (IN_BITS + 1)'(m >> (6 - SHIFT));
        sum = {1'b0, c} + bay;
        q   = sat_shift(sum);
    end

endmodule

// File: rtl/vga_timing_dither.sv
// VGA output stage: raster counters and syncs, coordinate publication to the
// renderer, a SRC_LAT-deep control delay line matching the renderer latency,
// and registered Bayer-dithered colour towards the DAC.
module vga_timing_dither
    import vga_pkg::*;
#(
    parameter int H_DISPLAY   = 1220,
    parameter int H_FRONT     = 31,
    parameter int H_SYNC      = 183,
    parameter int H_BACK      = 92,
    parameter int V_DISPLAY   = 480,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter int HSYNC_POL   = 0,
    parameter int VSYNC_POL   = 0,
    parameter int IN_BITS     = 6,
    parameter int OUT_BITS    = 2,
    parameter int SRC_LAT     = 0,
    parameter int DITHER_MODE = 2,
    parameter int FRAME_BITS  = 8
) (
    input logic                 clk48,
    input logic                 rst_n,
    vga_timing_dither_if.master bus
);
    localparam int H_TOTAL = timing_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL = timing_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);

    localparam logic [H_W-1:0] H_LAST   = H_W'(H_TOTAL - 1);
    localparam logic [H_W-1:0] H_DISP_C = H_W'(H_DISPLAY);
    localparam logic [H_W-1:0] HS_BEG   = H_W'(H_DISPLAY + H_FRONT);
    localparam logic [H_W-1:0] HS_END   = H_W'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [V_W-1:0] V_LAST   = V_W'(V_TOTAL - 1);
    localparam logic [V_W-1:0] V_DISP_C = V_W'(V_DISPLAY);
    localparam logic [V_W-1:0] VS_BEG   = V_W'(V_DISPLAY + V_FRONT);
    localparam logic [V_W-1:0] VS_END   = V_W'(V_DISPLAY + V_FRONT + V_SYNC);

    localparam logic HS_IDLE = (HSYNC_POL == 0);
    localparam logic VS_IDLE = (VSYNC_POL == 0);

    // "started" holds the counters at (0,0) for the first edge after reset so
    // that (0,0) is published by a clock edge like every other coordinate.
    logic                  started;
    logic [H_W-1:0]        h_cnt, h_nxt;
    logic [V_W-1:0]        v_cnt, v_nxt;
    logic [FRAME_BITS-1:0] frm_cnt, frm_nxt;
    logic                  hblank_r, fstart_r;

    // Next raster position: h wraps into v, v wraps into the frame counter.
    always_comb begin
        h_nxt   = h_cnt + H_W'(1);
        v_nxt   = v_cnt;
        frm_nxt = frm_cnt;
        if (!started) begin
            h_nxt = '0;
            v_nxt = '0;
        end else if (h_cnt == H_LAST) begin
            h_nxt = '0;
            if (v_cnt == V_LAST) begin
                v_nxt   = '0;
                frm_nxt = frm_cnt + FRAME_BITS'(1);
            end else begin
                v_nxt = v_cnt + V_W'(1);
            end
        end
    end

    // Counter and strobe registers; strobes decode the next position so they
    // change on the same edge as the counters they describe.
    always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
            started  <= 1'b0;
            h_cnt    <= '0;
            v_cnt    <= '0;
            frm_cnt  <= '0;
            hblank_r <= 1'b0;
            fstart_r <= 1'b0;
        end else begin
            started  <= 1'b1;
            h_cnt    <= h_nxt;
            v_cnt    <= v_nxt;
            frm_cnt  <= frm_nxt;
            hblank_r <= (h_nxt == H_DISP_C);
            fstart_r <= (h_nxt == '0) && (v_nxt == '0);
        end
    end

    // ---- stage p0: decode of the published coordinate ----
    logic       vld_p0, hs_p0, vs_p0;
    logic [2:0] bi_p0, bj_p0;
    logic       tgl_p0;

    assign tgl_p0 = (DITHER_MODE == int'(DM_TEMPORAL)) ? frm_cnt[0] : 1'b0;

    // Active area, sync windows and Bayer indices for the current coordinate.
    always_comb begin
        vld_p0 = started && (h_cnt < H_DISP_C) && (v_cnt < V_DISP_C);
        hs_p0  = started && (h_cnt >= HS_BEG) && (h_cnt < HS_END);
        vs_p0  = started && (v_cnt >= VS_BEG) && (v_cnt < VS_END);
        bi_p0  = h_cnt[2:0] ^ {2'b00, tgl_p0};
        bj_p0  = v_cnt[2:0];
    end

    // ---- stage p1: p0 delayed SRC_LAT clocks, aligned with source colour ----
    logic       vld_p1, hs_p1, vs_p1;
    logic [2:0] bi_p1, bj_p1;

    generate
        if (SRC_LAT == 0) begin : g_no_delay
            assign {vld_p1, hs_p1, vs_p1} = {vld_p0, hs_p0, vs_p0};
            assign {bi_p1, bj_p1}         = {bi_p0, bj_p0};
        end else begin : g_delay
            logic [2:0] ctl_sr [SRC_LAT];
            logic [5:0] pos_sr [SRC_LAT];

            // Control taps (active, syncs) clear to blank/inactive on reset.
            always_ff @(posedge clk48 or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < SRC_LAT; i++) begin
                        ctl_sr[i] <= 3'b000;
                    end
                end else begin
                    ctl_sr[0] <= {vld_p0, hs_p0, vs_p0};
                    for (int i = 1; i < SRC_LAT; i++) begin
                        ctl_sr[i] <= ctl_sr[i-1];
                    end
                end
            end

            // Dither indices ride along; they only matter when active is set.
            always_ff @(posedge clk48) begin
                pos_sr[0] <= {bi_p0, bj_p0};
                for (int i = 1; i < SRC_LAT; i++) begin
                    pos_sr[i] <= pos_sr[i-1];
                end
            end

            assign {vld_p1, hs_p1, vs_p1} = ctl_sr[SRC_LAT-1];
            assign {bi_p1, bj_p1}         = pos_sr[SRC_LAT-1];
        end
    endgenerate

    logic [OUT_BITS-1:0] q_r, q_g, q_b;

    bayer_dither #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS), .DITHER_MODE(DITHER_MODE))
        u_dith_r (.c(bus.src_r), .bi(bi_p1), .bj(bj_p1), .q(q_r));
    bayer_dither #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS), .DITHER_MODE(DITHER_MODE))
        u_dith_g (.c(bus.src_g), .bi(bi_p1), .bj(bj_p1), .q(q_g));
    bayer_dither #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS), .DITHER_MODE(DITHER_MODE))
        u_dith_b (.c(bus.src_b), .bi(bi_p1), .bj(bj_p1), .q(q_b));

    // ---- stage p2: DAC-facing output registers ----
    logic [OUT_BITS-1:0] r_p2, g_p2, b_p2;
    logic                hsync_p2, vsync_p2;

    // Blank colour outside the active area and drive syncs at their polarity.
    always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
            r_p2     <= '0;
            g_p2     <= '0;
            b_p2     <= '0;
            hsync_p2 <= HS_IDLE;
            vsync_p2 <= VS_IDLE;
        end else begin
            r_p2     <= vld_p1 ? q_r : '0;
            g_p2     <= vld_p1 ? q_g : '0;
            b_p2     <= vld_p1 ? q_b : '0;
            hsync_p2 <= hs_p1 ? ~HS_IDLE : HS_IDLE;
            vsync_p2 <= vs_p1 ? ~VS_IDLE : VS_IDLE;
        end
    end

    assign bus.h_count      = h_cnt;
    assign bus.v_count      = v_cnt;
    assign bus.frame        = frm_cnt;
    assign bus.hblank_start = hblank_r;
    assign bus.frame_start  = fstart_r;
    assign bus.r_out        = r_p2;
    assign bus.g_out        = g_p2;
    assign bus.b_out        = b_p2;
    assign bus.hsync        = hsync_p2;
    assign bus.vsync        = vsync_p2;

endmodule

// File: tb/tb_vga_timing_dither.sv
// Directed bench for vga_timing_dither. Instance A: default 1526x525 raster,
// SRC_LAT=3, spatial dither. Instance B: tiny 16x8 raster, SRC_LAT=0,
// temporal dither, active-high vsync. Expected values are hand-derived.
module tb_vga_timing_dither;

    logic clk48 = 1'b0;
    always #5 clk48 = ~clk48;

    logic rst_a_n;
    logic rst_b_n;
    int   tests = 0;
    int   fails = 0;

    vga_timing_dither_if #(.IN_BITS(6), .OUT_BITS(2), .FRAME_BITS(8)) bus_a ();
    vga_timing_dither_if #(.IN_BITS(6), .OUT_BITS(2), .FRAME_BITS(8)) bus_b ();

    vga_timing_dither #(
        .SRC_LAT(3), .DITHER_MODE(1)
    ) u_a (
        .clk48(clk48), .rst_n(rst_a_n), .bus(bus_a)
    );

    vga_timing_dither #(
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .HSYNC_POL(0), .VSYNC_POL(1), .SRC_LAT(0), .DITHER_MODE(2)
    ) u_b (
        .clk48(clk48), .rst_n(rst_b_n), .bus(bus_b)
    );

    // Expected A outputs for coordinates (0..4, 0): r=0x20, g=0x3F, b=0x14.
    logic [1:0] exp_r [5] = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd2};
    logic [1:0] exp_g [5] = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
    logic [1:0] exp_b [5] = '{2'd1, 2'd2, 2'd1, 2'd2, 2'd1};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_a(input int h, input int v, input int budget);
        int  n;
        logic hit;
        n   = 0;
        hit = (int'(bus_a.h_count) == h) && (int'(bus_a.v_count) == v);
        while (!hit && n < budget) begin
            @(negedge clk48);
            n++;
            hit = (int'(bus_a.h_count) == h) && (int'(bus_a.v_count) == v);
        end
        tests++;
        assert (hit) else begin
            fails++;
            $error("FAIL wait_a(%0d,%0d): observed h=%0d v=%0d after %0d clocks", h, v,
                   bus_a.h_count, bus_a.v_count, n);
        end
    endtask

    task automatic wait_b(input int h, input int v, input int f, input int budget);
        int  n;
        logic hit;
        n   = 0;
        hit = (int'(bus_b.h_count) == h) && (int'(bus_b.v_count) == v) &&
              (int'(bus_b.frame) == f);
        while (!hit && n < budget) begin
            @(negedge clk48);
            n++;
            hit = (int'(bus_b.h_count) == h) && (int'(bus_b.v_count) == v) &&
                  (int'(bus_b.frame) == f);
        end
        tests++;
        assert (hit) else begin
            fails++;
            $error("FAIL wait_b(%0d,%0d,f%0d): observed h=%0d v=%0d f=%0d", h, v, f,
                   bus_b.h_count, bus_b.v_count, bus_b.frame);
        end
    endtask

    initial begin
        int n;
        rst_a_n     = 1'b0;
        rst_b_n     = 1'b0;
        bus_a.src_r = 6'h20;
        bus_a.src_g = 6'h3F;
        bus_a.src_b = 6'h14;
        bus_b.src_r = 6'h14;
        bus_b.src_g = 6'h3F;
        bus_b.src_b = 6'h20;
        repeat (3) @(negedge clk48);

        // Reset values
        chk("a_rst_h", bus_a.h_count, 0);
        chk("a_rst_v", bus_a.v_count, 0);
        chk("a_rst_hsync", bus_a.hsync, 1);
        chk("a_rst_vsync", bus_a.vsync, 1);
        chk("a_rst_r", bus_a.r_out, 0);
        chk("a_rst_fstart", bus_a.frame_start, 0);
        chk("a_rst_hblank", bus_a.hblank_start, 0);

        // Release A: counters show 0,1,2 on successive edges
        rst_a_n = 1'b1;
        @(negedge clk48);
        chk("a_h0", bus_a.h_count, 0);
        chk("a_fstart0", bus_a.frame_start, 1);
        @(negedge clk48);
        chk("a_h1", bus_a.h_count, 1);
        chk("a_fstart1", bus_a.frame_start, 0);
        @(negedge clk48);
        chk("a_h2", bus_a.h_count, 2);

        // Spatial dither: coordinate (i,0) appears on the outputs at h_count=i+4
        wait_a(4, 0, 10);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("a_dith_r%0d", i), bus_a.r_out, exp_r[i]);
            chk($sformatf("a_dith_g%0d", i), bus_a.g_out, exp_g[i]);
            chk($sformatf("a_dith_b%0d", i), bus_a.b_out, exp_b[i]);
            @(negedge clk48);
        end

        // hblank_start strobe
        wait_a(1219, 0, 1300);
        chk("a_hblank_1219", bus_a.hblank_start, 0);
        @(negedge clk48);
        chk("a_hblank_1220", bus_a.hblank_start, 1);
        @(negedge clk48);
        chk("a_hblank_1221", bus_a.hblank_start, 0);

        // Horizontal blanking with the 4-clock offset
        wait_a(1223, 0, 10);
        chk("a_last_act_g", bus_a.g_out, 3);
        chk("a_last_act_b", bus_a.b_out, 2);
        @(negedge clk48);
        chk("a_blank_g", bus_a.g_out, 0);
        chk("a_blank_b", bus_a.b_out, 0);

        // hsync: low 4 clocks after h=1251, for 183 clocks
        wait_a(1254, 0, 100);
        chk("a_hsync_pre", bus_a.hsync, 1);
        @(negedge clk48);
        chk("a_hsync_fall", bus_a.hsync, 0);
        n = 0;
        while (bus_a.hsync === 1'b0 && n < 400) begin
            @(negedge clk48);
            n++;
        end
        chk("a_hsync_len", n, 183);
        chk("a_hsync_rise_h", bus_a.h_count, 1438);

        // Line wrap: (1525,0) blank, (0,1) active
        wait_a(3, 1, 200);
        chk("a_wrap_blank_g", bus_a.g_out, 0);
        @(negedge clk48);
        chk("a_line1_g", bus_a.g_out, 3);
        chk("a_line1_b", bus_a.b_out, 1);

        // Mid-line asynchronous reset during active video
        wait_a(200, 1, 300);
        chk("a_pre_rst_g", bus_a.g_out, 3);
        #2 rst_a_n = 1'b0;
        #1;
        chk("a_mid_rst_h", bus_a.h_count, 0);
        chk("a_mid_rst_v", bus_a.v_count, 0);
        chk("a_mid_rst_g", bus_a.g_out, 0);
        chk("a_mid_rst_r", bus_a.r_out, 0);
        @(negedge clk48);
        rst_a_n = 1'b1;
        @(negedge clk48);
        chk("a_rel_h0", bus_a.h_count, 0);
        @(negedge clk48);
        chk("a_rel_h1", bus_a.h_count, 1);
        @(negedge clk48);
        chk("a_rel_h2", bus_a.h_count, 2);

        // Mid-line asynchronous reset during the hsync pulse
        wait_a(1300, 0, 1400);
        chk("a_pre_rst_hsync", bus_a.hsync, 0);
        #2 rst_a_n = 1'b0;
        #1;
        chk("a_mid_rst_hsync", bus_a.hsync, 1);
        chk("a_mid_rst_h2", bus_a.h_count, 0);
        @(negedge clk48);
        rst_a_n = 1'b1;
        @(negedge clk48);
        chk("a_rel2_h0", bus_a.h_count, 0);

        // Instance B reset values (vsync active-high, so idles low)
        chk("b_rst_hsync", bus_b.hsync, 1);
        chk("b_rst_vsync", bus_b.vsync, 0);
        chk("b_rst_r", bus_b.r_out, 0);
        rst_b_n = 1'b1;
        @(negedge clk48);
        chk("b_h0", bus_b.h_count, 0);
        chk("b_fstart", bus_b.frame_start, 1);
        chk("b_frame0", bus_b.frame, 0);
        @(negedge clk48);
        chk("b_even_00_r", bus_b.r_out, 1);
        chk("b_even_00_g", bus_b.g_out, 3);
        @(negedge clk48);
        chk("b_even_10_r", bus_b.r_out, 2);

        wait_b(8, 0, 0, 20);
        chk("b_hblank", bus_b.hblank_start, 1);
        @(negedge clk48);
        chk("b_hblank_off", bus_b.hblank_start, 0);
        chk("b_hblank_g", bus_b.g_out, 0);
        @(negedge clk48);
        chk("b_hsync_pre", bus_b.hsync, 1);
        @(negedge clk48);
        chk("b_hsync_on", bus_b.hsync, 0);
        wait_b(13, 0, 0, 10);
        chk("b_hsync_last", bus_b.hsync, 0);
        @(negedge clk48);
        chk("b_hsync_off", bus_b.hsync, 1);

        // Vertical blanking and active-high vsync
        wait_b(1, 3, 0, 100);
        chk("b_v3_g", bus_b.g_out, 3);
        wait_b(1, 4, 0, 100);
        chk("b_v4_g", bus_b.g_out, 0);
        wait_b(0, 5, 0, 100);
        chk("b_vsync_pre", bus_b.vsync, 0);
        @(negedge clk48);
        chk("b_vsync_on", bus_b.vsync, 1);
        wait_b(0, 7, 0, 100);
        chk("b_vsync_last", bus_b.vsync, 1);
        @(negedge clk48);
        chk("b_vsync_off", bus_b.vsync, 0);

        // Frame wrap and temporal dither on odd/even frames
        wait_b(15, 7, 0, 100);
        chk("b_fstart_low", bus_b.frame_start, 0);
        @(negedge clk48);
        chk("b_wrap_h", bus_b.h_count, 0);
        chk("b_wrap_v", bus_b.v_count, 0);
        chk("b_wrap_frame", bus_b.frame, 1);
        chk("b_wrap_fstart", bus_b.frame_start, 1);
        @(negedge clk48);
        chk("b_odd_00_r", bus_b.r_out, 2);
        @(negedge clk48);
        chk("b_odd_10_r", bus_b.r_out, 1);
        wait_b(1, 0, 2, 200);
        chk("b_even2_00_r", bus_b.r_out, 1);

        // Frame counter modulo 2^FRAME_BITS
        wait_b(15, 7, 255, 40000);
        @(negedge clk48);
        chk("b_frame_mod", bus_b.frame, 0);
        chk("b_frame_mod_fstart", bus_b.frame_start, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
